ldm_stm_sequencer: RTL and testbench
====================================

# ldm_stm_sequencer

Multi-cycle block-transfer sequencer for the ARM7TDMI core. It drives the register file's read/write ports on one side and the data-memory port on the other to execute LDM/STM. For each set bit of a 16-bit register list, lowest register first, it either reads the register and stores it to memory (STM) or loads from memory and writes the register (LDM). It then optionally writes back the updated base address.

## Interface
Parameters:
- ADDR_W, 32, address and data width
- RLIST_W, 16, register-list width (R0..R15)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; 0 forces IDLE immediately
- start  in  1  command strobe; sampled only in IDLE
- load  in  1  1 = LDM, 0 = STM; captured at start
- up  in  1  1 = increment, 0 = decrement; captured at start
- pre  in  1  1 = pre-index (IB/DB), 0 = post-index (IA/DA); captured at start
- writeback  in  1  write the final base to base_reg; captured at start
- base_reg  in  4  base register number; captured at start
- base_addr  in  32  base register value; captured at start
- reg_list  in  16  register list; captured at start
- rf_read_num  out  4  register-file read select; equals the current register
- rf_read_data  in  32  asynchronous register-file read data
- rf_write_num  out  4  register-file write select
- rf_write_data  out  32  register-file write data
- rf_regwrite  out  1  register-file write enable
- mem_req  out  1  memory request, held until acked
- mem_we  out  1  1 = write (STM)
- mem_addr  out  32  word address
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data; valid when mem_ack = 1
- mem_ack  in  1  transfer complete; sampled at posedge while mem_req = 1
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse

## Operation
- n = popcount(reg_list), 5 bits (0..16).
- Start address, mod 2^32:
  - IA: base
  - IB: base+4
  - DA: base−4n+4
  - DB: base−4n
- Final base, mod 2^32: up ? base+4n : base−4n.
- Each transfer after the first uses address +4. Registers are always processed in ascending order.
- Registers: a pending-list register is loaded from reg_list at start. On each ack, the lowest set bit is cleared; current register = index of the lowest set bit.
- FSM states:
  - IDLE: start=1 and n≠0 → XFER. start=1 and n=0 → DONE; no memory access and no writeback.
  - XFER: mem_req=1, mem_we=!load, mem_addr=current address.
    - STM: mem_wdata=rf_read_data, with rf_read_num=current register.
    - LDM: when mem_ack=1, in the same cycle rf_regwrite=1, rf_write_num=current register, rf_write_data=mem_rdata.
    - On ack: if the list is now empty → WB if wb_en, else DONE. Otherwise stay in XFER with the next register and address.
  - WB: one cycle. rf_regwrite=1, rf_write_num=base_reg, rf_write_data=final base. Next state → DONE.
  - DONE: done=1 for one cycle. Next state → IDLE.
- wb_en = writeback && !(load && reg_list[base_reg]). For LDM with the base in the list, the loaded value wins.
- STM with the base in the list stores the original base value. WB occurs after all stores.
- Outside XFER: mem_req=0, mem_we=0, mem_wdata=0.
- rf_regwrite is high only as specified above.
- start is ignored when busy=1.

## Timing
- Reset values: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rf_read_num 0, rf_write_num 0, rf_write_data 0, rf_regwrite 0, busy 0, done 0. State = IDLE, pending list = 0.
- Start accepted at edge T: XFER from T+1 with mem_addr valid.
- Each transfer takes 1 cycle plus memory wait cycles. Zero-wait latency from start edge to done = n + 1 cycles, or n + 2 with WB. An empty list gives done at T+1.
- mem_addr and mem_we are stable while mem_req=1 and not acked.
- mem_ack while mem_req=0 is ignored.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs at reset values. Register writes already committed remain. No done pulse is produced.
- A new start is possible in the cycle after done: IDLE samples it.

## Test plan
- STM IA, base=0x1000, list=0x000A (R1, R3), R1=0x11, R3=0x33, writeback=1, zero-wait ack -> mem writes 0x1000←0x11, 0x1004←0x33; WB R(base_reg)=0x1008; done 4 cycles after start.
- LDM DB, base=0x2000, list=0x8001 (R0, R15), mem[0x1FF8]=0xA, mem[0x1FFC]=0xB, writeback=1, base_reg=R2 -> R0=0xA, R15=0xB, R2=0x1FF8.
- LDM IB, base_reg=R4, list includes R4, writeback=1, mem[base+4]=0xDEAD -> R4=0xDEAD; no WB cycle.
- Empty list with start -> done at T+1; mem_req never asserted; rf_regwrite never asserted.
- STM with 3 wait cycles per ack, plus a start pulse during busy -> addresses held during waits; the second start is ignored; done after 3×4+1 cycles.
- Reset driven low during the second transfer of a 4-register LDM -> outputs are 0 asynchronously; the first register is written and the rest are not; a following start runs normally.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer
// Block-transfer sequencer for LDM/STM. It walks the register list from the
// lowest set bit upward and moves one word per memory handshake. It then
// optionally writes the updated base back into the register file.
`timescale 1ns/1ps

module ldm_stm_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int RLIST_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       load,
    input  logic                       up,
    input  logic                       pre,
    input  logic                       writeback,
    input  logic [$clog2(RLIST_W)-1:0] base_reg,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic [RLIST_W-1:0]         reg_list,
    output logic [$clog2(RLIST_W)-1:0] rf_read_num,
    input  logic [ADDR_W-1:0]          rf_read_data,
    output logic [$clog2(RLIST_W)-1:0] rf_write_num,
    output logic [ADDR_W-1:0]          rf_write_data,
    output logic                       rf_regwrite,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [ADDR_W-1:0]          mem_wdata,
    input  logic [ADDR_W-1:0]          mem_rdata,
    input  logic                       mem_ack,
    output logic                       busy,
    output logic                       done
);

    localparam int IDX_W = $clog2(RLIST_W);
    localparam int CNT_W = $clog2(RLIST_W + 1);
    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [RLIST_W-1:0]   pending_q, pending_d;
    logic [RLIST_W-1:0]   pending_next;
    logic                 load_q;
    logic                 wb_en_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    final_q;
    logic [IDX_W-1:0]     base_reg_q;

    logic [CNT_W-1:0]     n_in;
    logic [ADDR_W-1:0]    span;
    logic [ADDR_W-1:0]    start_addr;
    logic [ADDR_W-1:0]    final_base;
    logic                 wb_en_in;
    logic                 accept;
    logic                 xfer_ack;
    logic [IDX_W-1:0]     cur_reg;

    function automatic logic [CNT_W-1:0] popcount(input logic [RLIST_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < RLIST_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Scanning downward leaves the lowest set bit as the final answer.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [RLIST_W-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = RLIST_W - 1; i >= 0; i--) begin
            if (v[i]) r = i[IDX_W-1:0];
        end
        return r;
    endfunction

    // Command decode: transfer count, first address and final base.
    always_comb begin
        n_in     = popcount(reg_list);
        span     = {{(ADDR_W-CNT_W-2){1'b0}}, n_in, 2'b00};
        wb_en_in = writeback && !(load && reg_list[base_reg]);
        case ({up, pre})
            2'b10:   start_addr = base_addr;
            2'b11:   start_addr = base_addr + WORD;
            2'b00:   start_addr = base_addr - span + WORD;
            default: start_addr = base_addr - span;
        endcase
        final_base = up ? (base_addr + span) : (base_addr - span);
    end

    assign accept       = (state_q == IDLE) && start;
    assign xfer_ack     = (state_q == XFER) && mem_ack;
    assign pending_next = pending_q & (pending_q - RLIST_W'(1));
    assign cur_reg      = lowest_idx(pending_q);
    assign rf_read_num  = cur_reg;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

    // Control state: FSM, pending list and captured command flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            load_q    <= 1'b0;
            wb_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (accept) begin
                load_q  <= load;
                wb_en_q <= wb_en_in;
            end
        end
    end

    // Datapath: the address steps by one word per completed transfer.
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q     <= start_addr;
            final_q    <= final_base;
            base_reg_q <= base_reg;
        end else if (xfer_ack) begin
            addr_q <= addr_q + WORD;
        end
    end

    // Next-state and port drive; every output is quiet outside its state.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rf_write_num  = '0;
        rf_write_data = '0;
        rf_regwrite   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pending_d = reg_list;
                    state_d   = (n_in == '0) ? DONE : XFER;
                end
            end
            XFER: begin
                mem_req  = 1'b1;
                mem_we   = !load_q;
                mem_addr = addr_q;
                if (!load_q) mem_wdata = rf_read_data;
                if (mem_ack) begin
                    pending_d = pending_next;
                    if (load_q) begin
                        rf_regwrite   = 1'b1;
                        rf_write_num  = cur_reg;
                        rf_write_data = mem_rdata;
                    end
                    if (pending_next == '0) state_d = wb_en_q ? WB : DONE;
                end
            end
            WB: begin
                rf_regwrite   = 1'b1;
                rf_write_num  = base_reg_q;
                rf_write_data = final_q;
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with a register-file model and a
// word memory that acknowledges after a programmable number of wait cycles.
`timescale 1ns/1ps

module tb_ldm_stm_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        load = 1'b0;
    logic        up = 1'b0;
    logic        pre = 1'b0;
    logic        writeback = 1'b0;
    logic [3:0]  base_reg = '0;
    logic [31:0] base_addr = '0;
    logic [15:0] reg_list = '0;
    logic [3:0]  rf_read_num;
    logic [31:0] rf_read_data;
    logic [3:0]  rf_write_num;
    logic [31:0] rf_write_data;
    logic        rf_regwrite;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;

    logic [31:0] rf  [16];
    logic [31:0] mem [1024];
    int          waits = 0;
    int          wcnt = 0;

    logic        pl_en = 1'b0;
    logic        pl_mem = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    int          rw_cnt = 0;
    int          req_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] mw_addr [$];
    logic [31:0] mw_data [$];

    int          vectors = 0;
    int          miscompares = 0;

    ldm_stm_sequencer #(.ADDR_W(32), .RLIST_W(16)) dut (
        .clock(clock), .reset(reset), .start(start), .load(load), .up(up),
        .pre(pre), .writeback(writeback), .base_reg(base_reg),
        .base_addr(base_addr), .reg_list(reg_list),
        .rf_read_num(rf_read_num), .rf_read_data(rf_read_data),
        .rf_write_num(rf_write_num), .rf_write_data(rf_write_data),
        .rf_regwrite(rf_regwrite), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    assign rf_read_data = rf[rf_read_num];
    assign mem_rdata    = mem[mem_addr[11:2]];
    assign mem_ack      = mem_req && (wcnt == waits);

    // Register-file / memory models, wait counter and event logging.
    always @(posedge clock) begin
        if (pl_en) begin
            if (pl_mem) mem[pl_addr[11:2]] <= pl_data;
            else        rf[pl_addr[3:0]]   <= pl_data;
        end
        if (rf_regwrite) begin
            rf[rf_write_num] <= rf_write_data;
            rw_cnt <= rw_cnt + 1;
        end
        if (mem_req && mem_ack && mem_we) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            mw_addr.push_back(mem_addr);
            mw_data.push_back(mem_wdata);
        end
        if (mem_req) req_cnt <= req_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic is_mem, input logic [31:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_mem  = is_mem;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic u, input logic p, input logic wb,
                         input logic [3:0] br, input logic [31:0] ba, input logic [15:0] rl);
        load      = ld;
        up        = u;
        pre       = p;
        writeback = wb;
        base_reg  = br;
        base_addr = ba;
        reg_list  = rl;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, inout int c, input int exp_c);
        while (done !== 1'b1 && c < 200) begin
            tick();
            c++;
        end
        check(tag, 32'(c), 32'(exp_c));
    endtask

    initial begin
        int c;
        int s_mw;
        int s_rw;
        int s_req;
        int s_done;

        // Reset state
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rf_regwrite", 32'(rf_regwrite), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_read_num", 32'(rf_read_num), 32'd0);
        reset = 1'b1;
        tick();

        // STM IA, R1/R3, writeback to R5
        preload(1'b0, 32'd1, 32'h11);
        preload(1'b0, 32'd3, 32'h33);
        s_mw = mw_addr.size();
        s_rw = rw_cnt;
        issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h1000, 16'h000A);
        c = 1;
        check("stm_ia_busy", 32'(busy), 32'd1);
        check("stm_ia_addr0", mem_addr, 32'h1000);
        check("stm_ia_we", 32'(mem_we), 32'd1);
        check("stm_ia_rnum0", 32'(rf_read_num), 32'd1);
        check("stm_ia_wdata0", mem_wdata, 32'h11);
        wait_done("stm_ia_latency", c, 4);
        check("stm_ia_nwr", 32'(mw_addr.size() - s_mw), 32'd2);
        if (mw_addr.size() - s_mw == 2) begin
            check("stm_ia_a0", mw_addr[s_mw], 32'h1000);
            check("stm_ia_d0", mw_data[s_mw], 32'h11);
            check("stm_ia_a1", mw_addr[s_mw+1], 32'h1004);
            check("stm_ia_d1", mw_data[s_mw+1], 32'h33);
        end
        check("stm_ia_wb", rf[5], 32'h1008);
        check("stm_ia_rwcnt", 32'(rw_cnt - s_rw), 32'd1);
        tick();
        check("stm_ia_done_pulse", 32'(done), 32'd0);
        check("stm_ia_idle", 32'(busy), 32'd0);

        // LDM DB, R0/R15, writeback to R2
        preload(1'b1, 32'h1FF8, 32'hA);
        preload(1'b1, 32'h1FFC, 32'hB);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h2000, 16'h8001);
        c = 1;
        check("ldm_db_addr0", mem_addr, 32'h1FF8);
        check("ldm_db_we", 32'(mem_we), 32'd0);
        check("ldm_db_regwrite", 32'(rf_regwrite), 32'd1);
        check("ldm_db_wnum0", 32'(rf_write_num), 32'd0);
        check("ldm_db_wdata0", rf_write_data, 32'hA);
        wait_done("ldm_db_latency", c, 4);
        check("ldm_db_r0", rf[0], 32'hA);
        check("ldm_db_r15", rf[15], 32'hB);
        check("ldm_db_r2", rf[2], 32'h1FF8);
        tick();

        // LDM IB with base R4 in the list: loaded value wins, no WB cycle
        preload(1'b1, 32'h3004, 32'hDEAD);
        preload(1'b1, 32'h3008, 32'h5555);
        preload(1'b0, 32'd4, 32'h1234);
        s_rw = rw_cnt;
        issue(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 32'h3000, 16'h0030);
        c = 1;
        check("ldm_ib_addr0", mem_addr, 32'h3004);
        wait_done("ldm_ib_latency", c, 3);
        check("ldm_ib_r4", rf[4], 32'hDEAD);
        check("ldm_ib_r5", rf[5], 32'h5555);
        check("ldm_ib_rwcnt", 32'(rw_cnt - s_rw), 32'd2);
        tick();

        // Empty list
        preload(1'b0, 32'd3, 32'h77);
        s_rw  = rw_cnt;
        s_req = req_cnt;
        issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h6000, 16'h0000);
        c = 1;
        check("empty_req_now", 32'(mem_req), 32'd0);
        wait_done("empty_latency", c, 1);
        tick();
        check("empty_reqcnt", 32'(req_cnt - s_req), 32'd0);
        check("empty_rwcnt", 32'(rw_cnt - s_rw), 32'd0);
        check("empty_r3", rf[3], 32'h77);

        // STM DA with 3 wait cycles and a start pulse while busy
        preload(1'b0, 32'd0, 32'hC0);
        preload(1'b0, 32'd1, 32'hC1);
        preload(1'b0, 32'd2, 32'hC2);
        waits = 3;
        s_mw = mw_addr.size();
        s_rw = rw_cnt;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 32'h4000, 16'h0007);
        c = 1;
        check("wait_addr_c1", mem_addr, 32'h3FF8);
        check("wait_ack_c1", 32'(mem_ack), 32'd0);
        check("wait_wdata_c1", mem_wdata, 32'hC0);
        load      = 1'b1;
        reg_list  = 16'hFFFF;
        base_addr = 32'h0;
        start     = 1'b1;
        tick();
        c++;
        start = 1'b0;
        check("wait_addr_c2", mem_addr, 32'h3FF8);
        check("wait_we_c2", 32'(mem_we), 32'd1);
        tick();
        c++;
        tick();
        c++;
        check("wait_ack_c4", 32'(mem_ack), 32'd1);
        check("wait_addr_c4", mem_addr, 32'h3FF8);
        wait_done("wait_latency", c, 13);
        check("wait_nwr", 32'(mw_addr.size() - s_mw), 32'd3);
        if (mw_addr.size() - s_mw == 3) begin
            check("wait_a0", mw_addr[s_mw], 32'h3FF8);
            check("wait_a1", mw_addr[s_mw+1], 32'h3FFC);
            check("wait_a2", mw_addr[s_mw+2], 32'h4000);
            check("wait_d2", mw_data[s_mw+2], 32'hC2);
        end
        check("wait_rwcnt", 32'(rw_cnt - s_rw), 32'd0);
        tick();
        check("wait_idle", 32'(busy), 32'd0);
        waits = 0;

        // Reset during the second transfer of a 4-register LDM
        preload(1'b1, 32'h5000, 32'h40);
        preload(1'b1, 32'h5004, 32'h41);
        preload(1'b1, 32'h5008, 32'h42);
        preload(1'b1, 32'h500C, 32'h43);
        preload(1'b0, 32'd4, 32'hE4);
        preload(1'b0, 32'd5, 32'hE5);
        preload(1'b0, 32'd6, 32'hE6);
        preload(1'b0, 32'd7, 32'hE7);
        s_done = done_cnt;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h5000, 16'h00F0);
        tick();
        check("abort_addr1", mem_addr, 32'h5004);
        reset = 1'b0;
        #1;
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_regwrite", 32'(rf_regwrite), 32'd0);
        check("abort_rnum", 32'(rf_read_num), 32'd0);
        check("abort_wdata", rf_write_data, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_r4", rf[4], 32'h40);
        check("abort_r5", rf[5], 32'hE5);
        check("abort_r6", rf[6], 32'hE6);
        check("abort_r7", rf[7], 32'hE7);
        check("abort_nodone", 32'(done_cnt - s_done), 32'd0);

        issue(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h5000, 16'h00F0);
        c = 1;
        wait_done("rerun_latency", c, 5);
        check("rerun_r5", rf[5], 32'h41);
        check("rerun_r7", rf[7], 32'h43);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
